llmint8_quant_ctrl: RTL and testbench

LLMINT8_QUANT_CTRL -- requirements
Module: llmint8_quant_ctrl

---
 rtl/llmint8_quant_ctrl_pkg.sv | 11 +
 rtl/llmint8_quant_ctrl_if.sv | 27 ++
 rtl/llmint8_quant_ctrl_quantizer.sv | 46 ++++
 rtl/llmint8_quant_ctrl.sv | 147 ++++++++++++++
 tb/tb_llmint8_quant_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/llmint8_quant_ctrl_pkg.sv
// Shared types and constants for the int8 quantization controller.
package llmint8_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam int unsigned QUANT_SCALE = 127;

endpackage

// File: rtl/llmint8_quant_ctrl_if.sv
// Beat-level streaming interface: input beats in, quantized beats out.
interface llmint8_quant_ctrl_if #(
    parameter int unsigned IN_WIDTH  = 16,
    parameter int unsigned N         = 4,
    parameter int unsigned OUT_WIDTH = 8
);

    logic signed [IN_WIDTH-1:0]  data_in [N];
    logic                        data_in_valid;
    logic                        data_in_ready;
    logic signed [OUT_WIDTH-1:0] data_out [N];
    logic                        data_out_valid;
    logic                        data_out_ready;
    logic                        data_out_last;
    logic [IN_WIDTH-1:0]         max_num_out;

    modport slave (
        input  data_in, data_in_valid, data_out_ready,
        output data_in_ready, data_out, data_out_valid, data_out_last, max_num_out
    );

    modport master (
        output data_in, data_in_valid, data_out_ready,
        input  data_in_ready, data_out, data_out_valid, data_out_last, max_num_out
    );

endinterface

// File: rtl/llmint8_quant_ctrl_quantizer.sv
// Per-beat quantizer: each element becomes round(x*127/absmax), half away from zero.
module quantizer_part
    import llmint8_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 16,
    parameter int unsigned N         = 4,
    parameter int unsigned OUT_WIDTH = 8
) (
    input  logic signed [IN_WIDTH-1:0]  i_data [N],
    input  logic [IN_WIDTH-1:0]         i_absmax,
    output logic signed [OUT_WIDTH-1:0] o_data [N]
);

    localparam int unsigned WW = IN_WIDTH + 9;

    logic [WW-1:0] w_absmax;
    logic [WW-1:0] w_den;

    // Zero absmax is never latched, but guard the divider for FILL-phase idling.
    always_comb begin
        w_absmax = (i_absmax == '0) ? WW'(1) : WW'(i_absmax);
        w_den    = w_absmax << 1;
    end

    for (genvar g = 0; g < N; g++) begin : g_elem
        logic                 w_neg;
        logic [IN_WIDTH-1:0]  w_mag;
        logic [WW-1:0]        w_num;
        logic [WW-1:0]        w_quo;
        logic [OUT_WIDTH-1:0] w_res;

        // (2*|x|*S + a) / (2*a) is |x|*S/a rounded half-up on the magnitude.
        always_comb begin
            w_neg = i_data[g][IN_WIDTH-1];
            w_mag = w_neg ? $unsigned(-i_data[g]) : $unsigned(i_data[g]);
            w_num = WW'(w_mag) * WW'(2 * QUANT_SCALE) + w_absmax;
            w_quo = w_num / w_den;
            if (w_quo > WW'(QUANT_SCALE)) begin
                w_quo = WW'(QUANT_SCALE);
            end
            w_res     = OUT_WIDTH'(w_quo);
            o_data[g] = w_neg ? -w_res : w_res;
        end
    end

endmodule

// File: rtl/llmint8_quant_ctrl.sv
// Tile quantization controller: buffers NUM_BEATS beats, tracks absmax, then drains int8 beats.
module llmint8_quant_ctrl
    import llmint8_pkg::*;
#(
    parameter int unsigned IN_WIDTH       = 16,
    parameter int unsigned IN_SIZE        = 4,
    parameter int unsigned IN_PARALLELISM = 1,
    parameter int unsigned OUT_WIDTH      = 8,
    parameter int unsigned NUM_BEATS      = 4
) (
    input logic                clk,
    input logic                rst,
    llmint8_quant_ctrl_if.slave bus
);

    localparam int unsigned N  = IN_SIZE * IN_PARALLELISM;
    localparam int unsigned CW = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CW-1:0]       LAST_BEAT = CW'(NUM_BEATS - 1);
    localparam logic [IN_WIDTH-1:0] NEG_MIN   = {1'b1, {(IN_WIDTH-1){1'b0}}};
    localparam logic [IN_WIDTH-1:0] POS_MAX   = {1'b0, {(IN_WIDTH-1){1'b1}}};

    state_t                      r_state;
    state_t                      w_next_state;
    logic [CW-1:0]               r_wr_cnt;
    logic [CW-1:0]               r_rd_cnt;
    logic [IN_WIDTH-1:0]         r_absmax_run;
    logic [IN_WIDTH-1:0]         r_absmax_lat;
    logic signed [IN_WIDTH-1:0]  r_buf [NUM_BEATS][N];

    logic [IN_WIDTH-1:0]         w_abs [N];
    logic [IN_WIDTH-1:0]         w_beat_max;
    logic [IN_WIDTH-1:0]         w_run_next;
    logic signed [OUT_WIDTH-1:0] w_q [N];
    logic                        w_in_hs;
    logic                        w_out_hs;
    logic                        w_wr_last;
    logic                        w_rd_last;

    // Saturating |x|: the most negative code maps to the largest positive one.
    for (genvar g = 0; g < N; g++) begin : g_abs
        always_comb begin
            if (!bus.data_in[g][IN_WIDTH-1]) begin
                w_abs[g] = $unsigned(bus.data_in[g]);
            end else if ($unsigned(bus.data_in[g]) == NEG_MIN) begin
                w_abs[g] = POS_MAX;
            end else begin
                w_abs[g] = $unsigned(-bus.data_in[g]);
            end
        end
    end

    always_comb begin
        w_beat_max = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (w_abs[i] > w_beat_max) begin
                w_beat_max = w_abs[i];
            end
        end
        w_run_next = (w_beat_max > r_absmax_run) ? w_beat_max : r_absmax_run;
    end

    always_comb begin
        w_in_hs   = (r_state == FILL) && bus.data_in_valid;
        w_out_hs  = (r_state == DRAIN) && bus.data_out_ready;
        w_wr_last = (r_wr_cnt == LAST_BEAT);
        w_rd_last = (r_rd_cnt == LAST_BEAT);
    end

    always_comb begin
        w_next_state       = r_state;
        bus.data_in_ready  = 1'b0;
        bus.data_out_valid = 1'b0;
        bus.data_out_last  = 1'b0;
        bus.max_num_out    = '0;
        case (r_state)
            FILL: begin
                bus.data_in_ready = 1'b1;
                if (w_in_hs && w_wr_last) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                bus.data_out_valid = 1'b1;
                bus.data_out_last  = w_rd_last;
                bus.max_num_out    = r_absmax_lat;
                if (w_out_hs && w_rd_last) begin
                    w_next_state = FILL;
                end
            end
            default: w_next_state = FILL;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            bus.data_out[i] = (r_state == DRAIN) ? w_q[i] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FILL;
            r_wr_cnt     <= '0;
            r_rd_cnt     <= '0;
            r_absmax_run <= '0;
            r_absmax_lat <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_in_hs) begin
                r_absmax_run <= w_run_next;
                if (w_wr_last) begin
                    r_wr_cnt     <= '0;
                    r_absmax_lat <= (w_run_next == '0) ? IN_WIDTH'(1) : w_run_next;
                end else begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
            end
            if (w_out_hs) begin
                if (w_rd_last) begin
                    r_rd_cnt     <= '0;
                    r_absmax_run <= '0;
                end else begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_hs) begin
            for (int unsigned i = 0; i < N; i++) begin
                r_buf[r_wr_cnt][i] <= bus.data_in[i];
            end
        end
    end

    quantizer_part #(
        .IN_WIDTH  (IN_WIDTH),
        .N         (N),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_quant (
        .i_data   (r_buf[r_rd_cnt]),
        .i_absmax (r_absmax_lat),
        .o_data   (w_q)
    );

endmodule

// File: tb/tb_llmint8_quant_ctrl.sv
// Bench for llmint8_quant_ctrl: tile-level reference model plus directed tiles.
module tb_llmint8_quant_ctrl;

    localparam int N  = 4;
    localparam int NB = 4;
    localparam int NT = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    llmint8_quant_ctrl_if #(.IN_WIDTH(16), .N(N), .OUT_WIDTH(8)) bus ();

    llmint8_quant_ctrl #(
        .IN_WIDTH       (16),
        .IN_SIZE        (4),
        .IN_PARALLELISM (1),
        .OUT_WIDTH      (8),
        .NUM_BEATS      (NB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int d [N];
        bit last;
        int mx;
    } beat_t;

    beat_t expq[$];
    int    tile_acc[$];
    int    vectors   = 0;
    int    fails     = 0;
    bit    armed     = 1'b0;
    int    tile_idx  = 0;
    int    obs      [NT][NB][N];
    int    obs_last [NT][NB];
    int    obs_max  [NT];

    function automatic int sat_abs(int x);
        if (x == -32768) return 32767;
        return (x < 0) ? -x : x;
    endfunction

    function automatic int quant(int x, int a);
        real v;
        v = real'(x) * 127.0 / real'(a);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    task automatic chk(input string name, input logic signed [31:0] act, input int exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_tile();
        int a;
        beat_t bt;
        a = 0;
        foreach (tile_acc[k]) if (sat_abs(tile_acc[k]) > a) a = sat_abs(tile_acc[k]);
        if (a == 0) a = 1;
        for (int b = 0; b < NB; b++) begin
            for (int i = 0; i < N; i++) bt.d[i] = quant(tile_acc[b*N+i], a);
            bt.last = (b == NB - 1);
            bt.mx   = a;
            expq.push_back(bt);
        end
        tile_acc.delete();
        tile_idx++;
    endtask

    // Model advances on the same handshakes the spec defines, judged from model state.
    always @(negedge clk) begin : compare
        bit ev;
        int b;
        int t;
        ev = (expq.size() > 0);
        if (armed) begin
            chk("out_valid", bus.data_out_valid, int'(ev));
            chk("in_ready", bus.data_in_ready, int'(!ev));
            if (ev) begin
                b = NB - expq.size();
                t = tile_idx - 1;
                chk("out_last", bus.data_out_last, int'(expq[0].last));
                chk("max_num_out", bus.max_num_out, expq[0].mx);
                for (int i = 0; i < N; i++) begin
                    chk($sformatf("data_out[%0d]", i), bus.data_out[i], expq[0].d[i]);
                    if (t >= 0 && t < NT) obs[t][b][i] = int'(bus.data_out[i]);
                end
                if (t >= 0 && t < NT) begin
                    obs_last[t][b] = int'(bus.data_out_last);
                    obs_max[t]     = int'(bus.max_num_out);
                end
            end else begin
                chk("idle_last", bus.data_out_last, 0);
                chk("idle_max", bus.max_num_out, 0);
                for (int i = 0; i < N; i++) chk($sformatf("idle_data[%0d]", i), bus.data_out[i], 0);
            end
        end
        if (rst) begin
            expq.delete();
            tile_acc.delete();
            armed = 1'b1;
        end else if (armed) begin
            if (ev && bus.data_out_ready) begin
                void'(expq.pop_front());
            end else if (!ev && bus.data_in_valid) begin
                for (int i = 0; i < N; i++) tile_acc.push_back(int'(bus.data_in[i]));
                if (tile_acc.size() == N * NB) load_tile();
            end
        end
    end

    task automatic send_tile(input int v [NB*N], input bit gap);
        for (int b = 0; b < NB; b++) begin
            for (int i = 0; i < N; i++) bus.data_in[i] = 16'(v[b*N+i]);
            bus.data_in_valid = 1'b1;
            @(posedge clk); #1;
            bus.data_in_valid = 1'b0;
            if (gap && b != NB - 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_done", expq.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int v [NB*N];
        foreach (obs[a, b, c]) obs[a][b][c] = -999;
        foreach (obs_last[a, b]) obs_last[a][b] = -999;
        foreach (obs_max[a]) obs_max[a] = -999;

        rst = 1'b1;
        bus.data_in_valid  = 1'b0;
        bus.data_out_ready = 1'b1;
        for (int i = 0; i < N; i++) bus.data_in[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Tile 0: uniform 100
        foreach (v[k]) v[k] = 100;
        send_tile(v, 1'b0);
        wait_drain();

        // Tile 1: one -200, rest 50
        foreach (v[k]) v[k] = 50;
        v[2*N+1] = -200;
        send_tile(v, 1'b0);
        wait_drain();

        // Tile 2: all zero
        foreach (v[k]) v[k] = 0;
        send_tile(v, 1'b0);
        wait_drain();

        // Tile 3: most negative code present
        foreach (v[k]) v[k] = 1000;
        v[0] = -32768;
        send_tile(v, 1'b0);
        wait_drain();

        // Tile 4: mixed values, input gaps, 3-cycle output stall with input pressure
        foreach (v[k]) v[k] = k * 37 - 250;
        send_tile(v, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        bus.data_out_ready = 1'b0;
        bus.data_in_valid  = 1'b1;
        for (int i = 0; i < N; i++) bus.data_in[i] = 16'sd999;
        repeat (3) begin @(posedge clk); #1; end
        bus.data_in_valid  = 1'b0;
        bus.data_out_ready = 1'b1;
        wait_drain();

        // Tile 5: reset after two output beats
        foreach (v[k]) v[k] = 300 - k * 11;
        send_tile(v, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Tile 6: fresh tile after reset
        for (int k = 0; k < NB*N; k++) begin
            case (k % 4)
                0: v[k] = 10;
                1: v[k] = -20;
                2: v[k] = 30;
                default: v[k] = -40;
            endcase
        end
        send_tile(v, 1'b0);
        wait_drain();

        chk("t0_max", obs_max[0], 100);
        chk("t0_out", obs[0][3][3], 127);
        chk("t0_last_b0", obs_last[0][0], 0);
        chk("t0_last_b3", obs_last[0][3], 1);
        chk("t1_max", obs_max[1], 200);
        chk("t1_neg", obs[1][2][1], -127);
        chk("t1_pos", obs[1][0][0], 32);
        chk("t2_max", obs_max[2], 1);
        chk("t2_out", obs[2][1][2], 0);
        chk("t3_max", obs_max[3], 32767);
        chk("t3_min", obs[3][0][0], -127);
        chk("t3_other", obs[3][0][1], 4);
        chk("t6_max", obs_max[6], 40);
        chk("t6_e0", obs[6][1][0], 32);
        chk("t6_e1", obs[6][1][1], -64);
        chk("t6_e2", obs[6][1][2], 95);
        chk("t6_e3", obs[6][1][3], -127);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
